// File: rtl/neosd_pkg.sv
// Shared neoSD definitions: clock-control sequencer states and the bit positions
// of the clock request / stall vectors driven into the SD clock generator.
package neosd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_DRAIN,
    ST_SETTLE
  } clk_ctrl_state_t;

  localparam int CLKREQ_CMD  = 0;
  localparam int CLKREQ_DATA = 1;
  localparam int CLKREQ_INIT = 2;

  localparam int CLKSTALL_SW   = 0;
  localparam int CLKSTALL_DATA = 1;

endpackage

// File: rtl/neosd_clk_ctrl.sv
// Clock sequencer for the neoSD clock generator: owns the divider select, runs the
// power-up init clock burst and merges CMD/DATA clock requests and stalls.
module neosd_clk_ctrl
  import neosd_pkg::*;
#(
  parameter logic [2:0]  INIT_CLKSEL = 3'd7,
  parameter int unsigned INIT_CLKS   = 80,
  parameter int unsigned SETTLE_CYC  = 256
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clkstrb_i,
  input  logic [2:0] cfg_clksel_i,
  input  logic       cfg_clksel_we_i,
  input  logic       init_req_i,
  input  logic       cmd_req_i,
  input  logic       rx_req_i,
  input  logic       tx_req_i,
  input  logic       rx_full_i,
  input  logic       tx_empty_i,
  output logic [2:0] sd_clksel_o,
  output logic [2:0] sd_clk_req_o,
  output logic [1:0] sd_clk_stall_o,
  output logic       busy_o,
  output logic       init_done_o
);

  localparam logic [15:0] INIT_LAST  = 16'(INIT_CLKS - 1);
  localparam logic [15:0] SETTLE_END = 16'(SETTLE_CYC);

  clk_ctrl_state_t state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [2:0]      sel_q, sel_d;
  logic [2:0]      pend_sel_q, pend_sel_d;
  logic            sel_pend_q, sel_pend_d;
  logic            init_pend_q, init_pend_d;
  logic [2:0]      req_q, req_d;
  logic [1:0]      stall_q, stall_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    pend_sel_d  = cfg_clksel_we_i ? cfg_clksel_i : pend_sel_q;
    sel_pend_d  = sel_pend_q | cfg_clksel_we_i;
    init_pend_d = init_pend_q | (init_req_i & (state_q != ST_INIT));
    done_d      = 1'b0;

    // IDLE looks at the freshly latched flags so a write or init pulse acts next cycle
    unique case (state_q)
      ST_IDLE: begin
        if (sel_pend_d) begin
          state_d = ST_DRAIN;
        end else if (init_pend_d) begin
          state_d     = ST_INIT;
          init_pend_d = 1'b0;
          cnt_d       = '0;
        end
      end
      ST_INIT: begin
        if (clkstrb_i) begin
          if (cnt_q == INIT_LAST) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      ST_DRAIN: begin
        if (clkstrb_i) begin
          sel_d      = pend_sel_q;
          sel_pend_d = cfg_clksel_we_i;
          cnt_d      = '0;
          state_d    = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q != SETTLE_END) begin
          cnt_d = cnt_q + 16'd1;
        end else if (clkstrb_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are derived from the next state
    req_d                = '0;
    stall_d              = '0;
    if (state_d == ST_INIT) begin
      req_d[CLKREQ_INIT] = 1'b1;
    end else begin
      req_d[CLKREQ_CMD]      = cmd_req_i;
      req_d[CLKREQ_DATA]     = rx_req_i | tx_req_i;
      stall_d[CLKSTALL_DATA] = (rx_req_i & rx_full_i) | (tx_req_i & tx_empty_i);
    end
    stall_d[CLKSTALL_SW] = (state_d == ST_DRAIN) || (state_d == ST_SETTLE);
    busy_d = (state_d != ST_IDLE) | sel_pend_d | init_pend_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sel_q       <= INIT_CLKSEL;
      pend_sel_q  <= INIT_CLKSEL;
      sel_pend_q  <= 1'b0;
      init_pend_q <= 1'b0;
      req_q       <= '0;
      stall_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      pend_sel_q  <= pend_sel_d;
      sel_pend_q  <= sel_pend_d;
      init_pend_q <= init_pend_d;
      req_q       <= req_d;
      stall_q     <= stall_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign sd_clksel_o    = sel_q;
  assign sd_clk_req_o   = req_q;
  assign sd_clk_stall_o = stall_q;
  assign busy_o         = busy_q;
  assign init_done_o    = done_q;

endmodule

// File: tb/tb_neosd_clk_ctrl.sv
// Directed bench for neosd_clk_ctrl: expectations are queued when stimulus is driven
// and popped against DUT outputs; the SD clock strobe fires every 4 clk cycles.
module tb_neosd_clk_ctrl;
  import neosd_pkg::*;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       clkstrb_i = 1'b0;
  logic [2:0] cfg_clksel_i = 3'd0;
  logic       cfg_clksel_we_i = 1'b0;
  logic       init_req_i = 1'b0;
  logic       cmd_req_i = 1'b0;
  logic       rx_req_i = 1'b0;
  logic       tx_req_i = 1'b0;
  logic       rx_full_i = 1'b0;
  logic       tx_empty_i = 1'b0;
  logic [2:0] sd_clksel_o;
  logic [2:0] sd_clk_req_o;
  logic [1:0] sd_clk_stall_o;
  logic       busy_o;
  logic       init_done_o;

  int total = 0;
  int bad = 0;
  int phase = 0;

  string       tag_q[$];
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  neosd_clk_ctrl #(
    .INIT_CLKSEL(3'd7),
    .INIT_CLKS  (80),
    .SETTLE_CYC (8)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .clkstrb_i      (clkstrb_i),
    .cfg_clksel_i   (cfg_clksel_i),
    .cfg_clksel_we_i(cfg_clksel_we_i),
    .init_req_i     (init_req_i),
    .cmd_req_i      (cmd_req_i),
    .rx_req_i       (rx_req_i),
    .tx_req_i       (tx_req_i),
    .rx_full_i      (rx_full_i),
    .tx_empty_i     (tx_empty_i),
    .sd_clksel_o    (sd_clksel_o),
    .sd_clk_req_o   (sd_clk_req_o),
    .sd_clk_stall_o (sd_clk_stall_o),
    .busy_o         (busy_o),
    .init_done_o    (init_done_o)
  );

  // One clk cycle; outputs are sampled 1ns after the edge, strobe is periodic.
  task automatic cyc();
    @(posedge clk);
    #1;
    phase = (phase + 1) % 4;
    clkstrb_i = (phase == 0);
  endtask

  task automatic push(input string t, input logic [15:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic pop(input logic [15:0] obs);
    string       t;
    logic [15:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL sb_empty got=%0h exp=none", obs);
      return;
    end
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", t, obs, e);
    end
    $display("check %-18s got=%0h exp=%0h", t, obs, e);
  endtask

  task automatic wait_idle(input string t);
    int k;
    for (k = 0; k < 3000; k++) begin
      if (!busy_o && sd_clk_stall_o == 2'b00) break;
      cyc();
    end
    push(t, 16'd0);
    pop({15'd0, k >= 3000});
  endtask

  initial begin
    int ns, nd, early, n, drops, sel_at, seen;
    logic prev_stall;
    logic [3:0] pat [5];
    logic [1:0] exp_dat [5];

    // Reset state
    rst_i = 1'b1;
    repeat (3) cyc();
    rst_i = 1'b0;
    cyc();
    push("rst_sel", 16'd7);     pop({13'd0, sd_clksel_o});
    push("rst_req", 16'd0);     pop({13'd0, sd_clk_req_o});
    push("rst_stall", 16'd0);   pop({14'd0, sd_clk_stall_o});
    push("rst_busy", 16'd0);    pop({15'd0, busy_o});
    push("rst_done", 16'd0);    pop({15'd0, init_done_o});

    // Init burst with cmd_req held high
    cmd_req_i  = 1'b1;
    init_req_i = 1'b1;
    cyc();
    init_req_i = 1'b0;
    push("init_req_vec", 16'h4); pop({13'd0, sd_clk_req_o});
    push("init_busy", 16'd1);    pop({15'd0, busy_o});
    ns = 0; nd = 0; early = 0;
    for (int i = 0; i < 2000; i++) begin
      if (init_done_o) nd++;
      if (sd_clk_req_o[CLKREQ_CMD] && nd == 0) early++;
      if (nd > 0) break;
      if (sd_clk_req_o == 3'b100 && clkstrb_i) ns++;
      cyc();
    end
    push("init_strobes", 16'd80);  pop(16'(ns));
    push("init_done_cnt", 16'd1);  pop(16'(nd));
    push("cmd_during_init", 16'd0); pop(16'(early));
    push("req_after_init", 16'h1); pop({13'd0, sd_clk_req_o});
    cyc();
    push("done_one_cycle", 16'd0); pop({15'd0, init_done_o});
    cmd_req_i = 1'b0;
    wait_idle("idle_after_init");

    // Select change to 2
    cfg_clksel_i = 3'd2; cfg_clksel_we_i = 1'b1;
    cyc();
    cfg_clksel_we_i = 1'b0;
    push("sw_stall_rise", 16'd1); pop({15'd0, sd_clk_stall_o[CLKSTALL_SW]});
    push("sw_sel_hold", 16'd7);   pop({13'd0, sd_clksel_o});
    for (int i = 0; i < 100; i++) begin
      if (sd_clk_stall_o[CLKSTALL_SW] && clkstrb_i) break;
      cyc();
    end
    cyc();
    push("sw_sel_new", 16'd2); pop({13'd0, sd_clksel_o});
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (!sd_clk_stall_o[CLKSTALL_SW]) break;
      n++;
      cyc();
    end
    push("settle_cycles", 16'd12); pop(16'(n));
    push("sw_busy_clear", 16'd0);  pop({15'd0, busy_o});

    // Writes 3 then 5: second write lands during SETTLE
    cfg_clksel_i = 3'd3; cfg_clksel_we_i = 1'b1;
    cyc();
    cfg_clksel_we_i = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (sd_clksel_o == 3'd3) break;
      cyc();
    end
    cyc(); cyc();
    cfg_clksel_i = 3'd5; cfg_clksel_we_i = 1'b1;
    cyc();
    cfg_clksel_we_i = 1'b0;
    drops = 0; prev_stall = sd_clk_stall_o[CLKSTALL_SW];
    for (int i = 0; i < 300; i++) begin
      if (prev_stall && !sd_clk_stall_o[CLKSTALL_SW]) drops++;
      prev_stall = sd_clk_stall_o[CLKSTALL_SW];
      if (!busy_o && !sd_clk_stall_o[CLKSTALL_SW]) break;
      cyc();
    end
    push("dbl_stall_drops", 16'd2); pop(16'(drops));
    push("dbl_final_sel", 16'd5);   pop({13'd0, sd_clksel_o});

    // Write and init in the same cycle: select must change before init clocks
    wait_idle("idle_before_both");
    cfg_clksel_i = 3'd1; cfg_clksel_we_i = 1'b1; init_req_i = 1'b1;
    cyc();
    cfg_clksel_we_i = 1'b0; init_req_i = 1'b0;
    seen = 0; sel_at = 0; nd = 0;
    for (int i = 0; i < 1500; i++) begin
      if (sd_clk_req_o[CLKREQ_INIT] && seen == 0) begin
        seen = 1;
        sel_at = int'(sd_clksel_o);
      end
      if (init_done_o) nd++;
      if (nd > 0 && !busy_o) break;
      cyc();
    end
    push("both_sel_first", 16'd1); pop(16'(sel_at));
    push("both_init_done", 16'd1); pop(16'(nd));

    // Data request / stall merge
    pat[0] = 4'b1100; exp_dat[0] = 2'b11;
    pat[1] = 4'b1000; exp_dat[1] = 2'b01;
    pat[2] = 4'b0011; exp_dat[2] = 2'b11;
    pat[3] = 4'b0110; exp_dat[3] = 2'b01;
    pat[4] = 4'b0101; exp_dat[4] = 2'b00;
    for (int p = 0; p < 5; p++) begin
      {rx_req_i, rx_full_i, tx_req_i, tx_empty_i} = pat[p];
      push($sformatf("dat_stall_%0d", p), {15'd0, exp_dat[p][1]});
      push($sformatf("dat_req_%0d", p), {15'd0, exp_dat[p][0]});
      cyc();
      pop({15'd0, sd_clk_stall_o[CLKSTALL_DATA]});
      pop({15'd0, sd_clk_req_o[CLKREQ_DATA]});
    end
    {rx_req_i, rx_full_i, tx_req_i, tx_empty_i} = 4'b0000;
    cyc();

    // Reset in the middle of the burst, with a select write pending
    wait_idle("idle_before_abort");
    init_req_i = 1'b1;
    cyc();
    init_req_i = 1'b0;
    cyc();
    cfg_clksel_i = 3'd6; cfg_clksel_we_i = 1'b1;
    cyc();
    cfg_clksel_we_i = 1'b0;
    ns = 0;
    for (int i = 0; i < 1000; i++) begin
      if (sd_clk_req_o == 3'b100 && clkstrb_i) ns++;
      if (ns == 40) break;
      cyc();
    end
    rst_i = 1'b1;
    cyc();
    push("abort_strobes", 16'd40); pop(16'(ns));
    push("abort_sel", 16'd7);      pop({13'd0, sd_clksel_o});
    push("abort_req", 16'd0);      pop({13'd0, sd_clk_req_o});
    push("abort_stall", 16'd0);    pop({14'd0, sd_clk_stall_o});
    push("abort_busy", 16'd0);     pop({15'd0, busy_o});
    push("abort_done", 16'd0);     pop({15'd0, init_done_o});
    rst_i = 1'b0;
    nd = 0; n = 0;
    for (int i = 0; i < 500; i++) begin
      if (init_done_o) nd++;
      if (sd_clk_req_o[CLKREQ_INIT] || sd_clk_stall_o[CLKSTALL_SW]) n++;
      cyc();
    end
    push("post_abort_done", 16'd0);  pop(16'(nd));
    push("post_abort_activity", 16'd0); pop(16'(n));
    push("post_abort_sel", 16'd7);   pop({13'd0, sd_clksel_o});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/neosd_clk_ctrl.md
# neosd_clk_ctrl

Sequencer in front of the neoSD clock generator. Owns the SD clock-divider select, runs the card power-up init clock burst (≥74 SD clocks), and merges clock requests and stalls from the CMD FSM, DATA RX and DATA TX into the generator's `sd_clk_req`/`sd_clk_stall` inputs. Divider changes are glitch-free: the SD clock is stalled low, the select is switched, and the block waits for the divider to settle before releasing.

## Interface
- `INIT_CLKSEL`, 3'd7: divider select after reset (slowest, identification rate).
- `INIT_CLKS`, 80: SD clock cycles in the init burst, range 74..255.
- `SETTLE_CYC`, 256: `clk_i` cycles waited after a select change, range 1..65535.

- `clk_i` in 1: system clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `clkstrb_i` in 1: one-cycle strobe from the generator, one per SD clock period (falling edge).
- `cfg_clksel_i` in 3: requested divider select.
- `cfg_clksel_we_i` in 1: write strobe for `cfg_clksel_i`.
- `init_req_i` in 1: pulse, start init burst.
- `cmd_req_i` in 1: CMD FSM needs the clock.
- `rx_req_i` / `tx_req_i` in 1 each: DATA read/write needs the clock.
- `rx_full_i` in 1: RX buffer full.
- `tx_empty_i` in 1: TX buffer empty.
- `sd_clksel_o` out 3: divider select to the generator.
- `sd_clk_req_o` out 3: [0] CMD, [1] DATA, [2] init.
- `sd_clk_stall_o` out 2: [0] switch stall, [1] data flow stall.
- `busy_o` out 1: state ≠ IDLE, or an init or select change is pending.
- `init_done_o` out 1: one-cycle pulse at burst end.

## Operation
- All outputs are registered. Reset values:
  - `sd_clksel_o` = `INIT_CLKSEL`.
  - Every other output = 0.
  - State = IDLE.
  - Pending flags cleared.
  - Counters cleared.
- Pending latches:
  - `cfg_clksel_we_i` stores `cfg_clksel_i` in `pend_sel` and sets `sel_pend`. The last write wins and is accepted in any state.
  - `init_req_i` sets `init_pend`. It is ignored while in INIT.
- FSM states: IDLE, INIT, DRAIN, SETTLE.
  - **IDLE**
    - `sel_pend` → DRAIN.
    - Else `init_pend` → INIT (clear `init_pend`, counter = 0).
    - A select change always wins over init, so init runs at the new rate.
  - **INIT**
    - `sd_clk_req_o[2]` = 1; `sd_clk_req_o[1:0]` = 0.
    - Counter increments on each `clkstrb_i`.
    - At the strobe where counter = `INIT_CLKS-1`: go to IDLE, pulse `init_done_o`.
  - **DRAIN**
    - `sd_clk_stall_o[0]` = 1.
    - On the first `clkstrb_i`: load `sd_clksel_o` ← `pend_sel`, clear `sel_pend`, counter = 0, go to SETTLE.
  - **SETTLE**
    - `sd_clk_stall_o[0]` stays 1.
    - Count `SETTLE_CYC` `clk_i` cycles, then wait for the next `clkstrb_i`, then go to IDLE.
    - A write arriving during SETTLE re-sets `sel_pend`, so IDLE immediately re-enters DRAIN.
- Request merge, all states except INIT:
  - `sd_clk_req_o[0]` = `cmd_req_i`.
  - `sd_clk_req_o[1]` = `rx_req_i | tx_req_i`.
  - `sd_clk_req_o[2]` = 0.
- Data stall: `sd_clk_stall_o[1]` = (`rx_req_i & rx_full_i`) | (`tx_req_i & tx_empty_i`). It is forced to 0 in INIT.
- In-flight transfers during DRAIN/SETTLE keep their req bits. The clock simply stops low, which is legal for SD.

## Timing
- Input to `sd_clk_req_o`/`sd_clk_stall_o` change: 1 cycle.
- Write in IDLE to `sd_clksel_o` update: 1 cycle (IDLE→DRAIN), plus wait for the first strobe, plus 1 cycle.
- Write to IDLE, minimum: `SETTLE_CYC` + two strobe waits + 2 cycles.
- `clkstrb_i` in the same cycle as DRAIN entry is not counted. DRAIN waits for a strobe seen while the stall is already registered high.
- `init_done_o` is high exactly one cycle, in the first IDLE cycle after the burst.
- `rst_i` mid-INIT or mid-SETTLE:
  - Abort without `init_done_o`.
  - Select returns to `INIT_CLKSEL`.
  - Pending writes are lost.
- Simultaneous `cfg_clksel_we_i` and `init_req_i` in IDLE: both latch; DRAIN → SETTLE → IDLE → INIT.

## Structure
- Shared package `neosd_pkg`:
  - state enum `clk_ctrl_state_t`.
  - index constants `CLKREQ_CMD`=0, `CLKREQ_DATA`=1, `CLKREQ_INIT`=2.
  - `CLKSTALL_SW`=0, `CLKSTALL_DATA`=1.
- Single module, no sub-modules. One shared 16-bit counter serves both INIT and SETTLE.

## Test plan
- Reset, `INIT_CLKSEL`=7 → `sd_clksel_o`=7; `sd_clk_req_o`=0, `sd_clk_stall_o`=0, `busy_o`=0.
- `init_req_i` pulse, strobe every 4 cycles → `sd_clk_req_o`=3'b100 for exactly 80 strobes; `init_done_o` pulses once; `cmd_req_i` held high shows on `sd_clk_req_o[0]` only after the burst.
- In IDLE, write sel=2, `SETTLE_CYC`=8:
  - stall[0] rises next cycle.
  - `sd_clksel_o`=2 one cycle after the next strobe.
  - stall[0] stays high ≥8 cycles plus one strobe, then drops.
- Writes 3 then 5 during SETTLE → second DRAIN occurs; final `sd_clksel_o`=5.
- Write plus `init_req_i` in the same cycle → select updated before any `sd_clk_req_o[2]`.
- `rx_req_i`=1, `rx_full_i`=1 → `sd_clk_stall_o[1]`=1.
- `rst_i` at burst strobe 40 → no `init_done_o`; all outputs at reset values next cycle.
